// File: rtl/ssd_scan_driver_if.sv
// ssd_scan_driver bus: display data in, pin drive out.
// master = game logic side, slave = scan driver side.
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int DIM_BITS   = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    lz_blank;
  logic                    load;
  logic [DIM_BITS-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   an_n;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic                    frame_done;

  modport master (
    output value, dp_in, digit_en, lz_blank, load, brightness,
    input  an_n, seg_n, dp_n, frame_done
  );

  modport slave (
    input  value, dp_in, digit_en, lz_blank, load, brightness,
    output an_n, seg_n, dp_n, frame_done
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// N-digit multiplexed seven-segment scan driver with
// frame-synchronous loading, blanking and PWM dimming.
module ssd_scan_driver #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 17,
  parameter int DIM_BITS   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ssd_scan_driver_if.slave bus
);

  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  logic [SCAN_DIV-1:0]     presc;
  logic [IW-1:0]           idx;
  logic                    slot_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic                    sh_lz;
  logic                    pending;

  logic [4*NUM_DIGITS-1:0] act_value;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_en;
  logic                    act_lz;

  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    seen;
  logic                    en_cur;
  logic                    duty;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign slot_end  = &presc;
  assign frame_end = slot_end && (idx == LAST);

  // Free-running slot prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + SCAN_DIV'(1);
  end

  // Digit index steps once per slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (slot_end) begin
      idx <= (idx == LAST) ? '0 : idx + IW'(1);
    end
  end

  // Shadow capture; applied to active only at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value  <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
      sh_lz     <= 1'b0;
      pending   <= 1'b0;
      act_value <= '0;
      act_dp    <= '0;
      act_en    <= '0;
      act_lz    <= 1'b0;
    end else if (frame_end) begin
      pending <= 1'b0;
      if (bus.load) begin
        act_value <= bus.value;
        act_dp    <= bus.dp_in;
        act_en    <= bus.digit_en;
        act_lz    <= bus.lz_blank;
      end else if (pending) begin
        act_value <= sh_value;
        act_dp    <= sh_dp;
        act_en    <= sh_en;
        act_lz    <= sh_lz;
      end
    end else if (bus.load) begin
      sh_value <= bus.value;
      sh_dp    <= bus.dp_in;
      sh_en    <= bus.digit_en;
      sh_lz    <= bus.lz_blank;
      pending  <= 1'b1;
    end
  end

  // Next pin levels for the digit currently in its slot.
  always_comb begin
    nib     = act_value[{idx, 2'b00} +: 4];
    seen    = 1'b0;
    lz_mask = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (act_value[4*i +: 4] != 4'h0) seen = 1'b1;
      lz_mask[i] = act_lz & ~seen;
    end
    en_cur = act_en[idx];
    duty   = presc[SCAN_DIV-1 -: DIM_BITS] <= bus.brightness;
    an_d   = '1;
    if (en_cur && duty && (presc != '0)) an_d[idx] = 1'b0;
    seg_d  = '1;
    if (en_cur && !lz_mask[idx]) seg_d = hex7(nib);
    dp_d   = ~(en_cur & act_dp[idx]);
  end

  // Registered pin drive and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an_n       <= '1;
      bus.seg_n      <= '1;
      bus.dp_n       <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.an_n       <= an_d;
      bus.seg_n      <= seg_d;
      bus.dp_n       <= dp_d;
      bus.frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Testbench for ssd_scan_driver (4 digits, 16-clk slots).
// Cycle model derived from elapsed time since reset.
module tb_ssd_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int DB = 2;
  localparam logic [6:0] HEX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [12:0] DARK = {4'hF, 7'h7F, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ssd_scan_driver_if #(.NUM_DIGITS(ND), .DIM_BITS(DB)) bus ();

  ssd_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DIM_BITS(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [12:0] obs;
  assign obs = {bus.an_n, bus.seg_n, bus.dp_n, bus.frame_done};

  // Reference model: t = clocks since reset release.
  int          t = 0;
  int          mp, md;
  logic        mon, mfe, pend = 1'b0;
  logic [6:0]  mseg;
  logic [15:0] a_val = '0, s_val = '0;
  logic [3:0]  a_dp = '0, a_en = '0, s_dp = '0, s_en = '0;
  logic        a_lz = 1'b0, s_lz = 1'b0;
  logic [12:0] expv = DARK;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0; pend = 0;
      a_val = '0; a_dp = '0; a_en = '0; a_lz = 0;
      s_val = '0; s_dp = '0; s_en = '0; s_lz = 0;
      expv = DARK;
    end else begin
      mp  = t % 16;
      md  = (t / 16) % 4;
      mon = a_en[md] && (mp / 4 <= int'(bus.brightness))
            && mp != 0;
      if (!a_en[md]) mseg = 7'h7F;
      else if (a_lz && md > 0 && (a_val >> (4 * md)) == 0)
        mseg = 7'h7F;
      else mseg = HEX[(a_val >> (4 * md)) & 16'hF];
      mfe  = (t % 64) == 63;
      expv = {mon ? ~(4'b1 << md) : 4'hF, mseg,
              !(a_en[md] && a_dp[md]), mfe};
      if (mfe) begin
        if (bus.load) begin
          a_val = bus.value; a_dp = bus.dp_in;
          a_en = bus.digit_en; a_lz = bus.lz_blank;
        end else if (pend) begin
          a_val = s_val; a_dp = s_dp;
          a_en = s_en; a_lz = s_lz;
        end
        pend = 0;
      end else if (bus.load) begin
        s_val = bus.value; s_dp = bus.dp_in;
        s_en = bus.digit_en; s_lz = bus.lz_blank;
        pend = 1;
      end
      t++;
    end
  end

  task automatic do_load(input logic [15:0] v,
                         input logic [3:0] dp,
                         input logic [3:0] en,
                         input logic lz);
    bus.value = v; bus.dp_in = dp;
    bus.digit_en = en; bus.lz_blank = lz;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_frame();
    bit got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL wait_model t=%0t got %h want %h",
                 $time, obs, expv);
      end
      if (bus.frame_done === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL frame_timeout got none want pulse");
    end
  endtask

  task automatic test_reset();
    int pulses = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== DARK) begin
      n_bad++;
      $display("FAIL reset_state got %h want %h", obs, DARK);
    end
    rst_n = 1'b1;
    repeat (200) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv || obs[12:1] !== DARK[12:1]) begin
        n_bad++;
        $display("FAIL idle got %h want %h", obs, expv);
      end
      if (bus.frame_done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 3) begin
      n_bad++;
      $display("FAIL idle_pulses got %0d want 3", pulses);
    end
  endtask

  task automatic test_hex();
    logic [6:0] ws [4] = '{7'b0111000, 7'b0001000,
                           7'b0010010, 7'b1001111};
    int lows [4] = '{0, 0, 0, 0};
    bus.brightness = 2'd3;
    do_load(16'h12AF, 4'b0010, 4'hF, 1'b0);
    wait_frame();
    repeat (64) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL hex_model got %h want %h", obs, expv);
      end
      for (int k = 0; k < 4; k++) begin
        if (bus.an_n[k] === 1'b0) begin
          lows[k]++;
          n_cmp++;
          if (bus.seg_n !== ws[k] || bus.dp_n !== (k != 1)) begin
            n_bad++;
            $display("FAIL hex_digit%0d got %b/%b want %b/%b",
                     k, bus.seg_n, bus.dp_n, ws[k], k != 1);
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (lows[k] != 15) begin
        n_bad++;
        $display("FAIL hex_ontime%0d got %0d want 15", k, lows[k]);
      end
    end
  endtask

  task automatic test_lz();
    logic [6:0] w1 [4] = '{7'b0000001, 7'b0000110,
                           7'h7F, 7'h7F};
    logic [6:0] w2 [4] = '{7'b0000001, 7'h7F, 7'h7F, 7'h7F};
    for (int pass = 0; pass < 2; pass++) begin
      do_load(pass == 0 ? 16'h0030 : 16'h0000, 4'h0, 4'hF, 1'b1);
      wait_frame();
      repeat (64) begin
        @(negedge clk);
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL lz_model got %h want %h", obs, expv);
        end
        for (int k = 0; k < 4; k++) begin
          if (bus.an_n[k] === 1'b0) begin
            n_cmp++;
            if (bus.seg_n !== (pass == 0 ? w1[k] : w2[k])) begin
              n_bad++;
              $display("FAIL lz%0d_digit%0d got %b", pass, k,
                       bus.seg_n);
            end
          end
        end
      end
    end
  endtask

  task automatic test_shadow();
    bit got = 0;
    bus.lz_blank = 1'b0;
    wait_frame();
    repeat (10) @(negedge clk);
    do_load(16'h1111, 4'h0, 4'hF, 1'b0);
    repeat (10) @(negedge clk);
    do_load(16'h2222, 4'h0, 4'hF, 1'b0);
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv || bus.seg_n === 7'b1001111) begin
        n_bad++;
        $display("FAIL shadow_hold got %h want %h", obs, expv);
      end
      if (bus.frame_done === 1'b1) got = 1;
    end
    repeat (64) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv ||
          (bus.an_n != 4'hF && bus.seg_n !== 7'b0010010)) begin
        n_bad++;
        $display("FAIL shadow_new got %h want %h", obs, expv);
      end
    end
  endtask

  task automatic test_bright();
    int hi;
    logic [3:0] want;
    for (int b = 0; b < 2; b++) begin
      bus.brightness = 2'(b);
      hi = (b == 0) ? 3 : 7;
      wait_frame();
      for (int m = 0; m < 64; m++) begin
        @(negedge clk);
        want = (m % 16 >= 1 && m % 16 <= hi)
               ? ~(4'b1 << (m / 16)) : 4'hF;
        n_cmp++;
        if (bus.an_n !== want || obs !== expv) begin
          n_bad++;
          $display("FAIL bright%0d m=%0d got %b want %b",
                   b, m, bus.an_n, want);
        end
      end
    end
    bus.brightness = 2'd3;
  endtask

  task automatic test_enable();
    do_load(16'h5A3C, 4'hF, 4'b0101, 1'b0);
    wait_frame();
    repeat (64) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv || bus.an_n[1] !== 1'b1 ||
          bus.an_n[3] !== 1'b1) begin
        n_bad++;
        $display("FAIL enable got %h want %h", obs, expv);
      end
    end
  endtask

  task automatic test_same_cycle();
    int hits = 0;
    wait_frame();
    repeat (63) @(negedge clk);
    bus.value = 16'hBEEF; bus.dp_in = 4'h0;
    bus.digit_en = 4'hF; bus.lz_blank = 1'b0;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    n_cmp++;
    if (bus.frame_done !== 1'b1) begin
      n_bad++;
      $display("FAIL same_cycle_fd got %b want 1", bus.frame_done);
    end
    repeat (64) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL same_cycle got %h want %h", obs, expv);
      end
      if (bus.an_n === 4'b1110 && bus.seg_n === 7'b0111000) hits++;
    end
    n_cmp++;
    if (hits != 15) begin
      n_bad++;
      $display("FAIL same_cycle_d0 got %0d want 15", hits);
    end
  endtask

  task automatic test_random();
    repeat (1500) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv) begin
        n_bad++;
        $display("FAIL random t=%0t got %h want %h",
                 $time, obs, expv);
      end
      bus.load = ($urandom % 24) == 0;
      if (bus.load) begin
        bus.value = 16'($urandom);
        if ($urandom % 3 == 0) bus.value[15:8] = 8'h00;
        bus.dp_in = 4'($urandom);
        bus.digit_en = 4'($urandom);
        bus.lz_blank = 1'($urandom);
      end
      if ($urandom % 90 == 0) bus.brightness = 2'($urandom);
    end
    @(negedge clk);
    bus.load = 1'b0;
    bus.brightness = 2'd3;
  endtask

  task automatic test_reset_mid();
    wait_frame();
    repeat (5) @(negedge clk);
    do_load(16'h7777, 4'hF, 4'hF, 1'b0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== DARK) begin
      n_bad++;
      $display("FAIL reset_async got %h want %h", obs, DARK);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (140) begin
      @(negedge clk);
      n_cmp++;
      if (obs !== expv || obs[12:1] !== DARK[12:1]) begin
        n_bad++;
        $display("FAIL reset_discard got %h want %h", obs, expv);
      end
    end
  endtask

  initial begin
    bus.value = '0; bus.dp_in = '0; bus.digit_en = '0;
    bus.lz_blank = 1'b0; bus.load = 1'b0;
    bus.brightness = 2'd3;
    test_reset();
    test_hex();
    test_lz();
    test_shadow();
    test_bright();
    test_enable();
    test_same_cycle();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
